// File: rtl/spi_display_slave_pkg.sv
// Shared definitions for the countdown display SPI slave.
//   FRAME_BITS    : bits per SPI frame, MSB first
//   CMD_*         : command codes carried in frame[15:12]
//   MODE_*        : bit positions inside the 2-bit mode register
//   SEG_BLANK/DASH: active-low glyphs {g,f,e,d,c,b,a}
//   spi_state_t   : SPI receive FSM states
package disp_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [3:0] CMD_NOP  = 4'd0;
    localparam logic [3:0] CMD_DIG0 = 4'd1;
    localparam logic [3:0] CMD_DIG1 = 4'd2;
    localparam logic [3:0] CMD_DIG2 = 4'd3;
    localparam logic [3:0] CMD_DIG3 = 4'd4;
    localparam logic [3:0] CMD_MODE = 4'd5;

    localparam int MODE_BLINK = 0;
    localparam int MODE_DP    = 1;

    // Digit that carries the min:sec separator when MODE_DP is set.
    localparam logic [1:0] DP_DIGIT = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } spi_state_t;

    // Commands above CMD_MODE are rejected as bad frames.
    function automatic logic cmd_legal(input logic [3:0] cmd);
        return cmd <= CMD_MODE;
    endfunction

endpackage

// File: rtl/spi_display_slave_if.sv
// SPI pin bundle between the countdown master and the display slave.
//   ss   : slave select, active-low (master -> slave)
//   sclk : SPI clock, mode 0       (master -> slave)
//   mosi : data to slave           (master -> slave)
//   miso : echo of last frame      (slave -> master)
interface spi_display_slave_if;

    logic ss;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (output ss, output sclk, output mosi, input miso);
    modport slave  (input ss, input sclk, input mosi, output miso);

endinterface

// File: rtl/spi_display_slave_seg7_decode.sv
// 4-bit digit code to active-low 7-segment pattern {g,f,e,d,c,b,a}.
//   i_code : 0-9 digit glyphs, 10 dash, 11-15 blank
//   o_seg  : segment drive, 0 = lit
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    // NOTE: every path through a combinational case assigns the output
    // (the default arm here), otherwise synthesis infers a latch.
    always_comb begin
        case (i_code)
            4'd0:    o_seg = 7'h40;
            4'd1:    o_seg = 7'h79;
            4'd2:    o_seg = 7'h24;
            4'd3:    o_seg = 7'h30;
            4'd4:    o_seg = 7'h19;
            4'd5:    o_seg = 7'h12;
            4'd6:    o_seg = 7'h02;
            4'd7:    o_seg = 7'h78;
            4'd8:    o_seg = 7'h00;
            4'd9:    o_seg = 7'h10;
            4'd10:   o_seg = SEG_DASH;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/spi_display_slave.sv
// SPI slave for the countdown display: receives 16-bit command frames,
// holds four BCD digits plus a 2-bit mode, scans a multiplexed 4-digit
// 7-segment display and echoes the last accepted frame on miso.
//   clk, rst     : system clock, asynchronous active-low reset
//   spi          : ss/sclk/mosi in, miso out (oversampled, sclk <= clk/4)
//   seg, dp, an  : active-low segments, decimal point, digit anodes
//   mode_o       : current mode register {dp_enable, blink_enable}
//   frame_valid  : 1-cycle pulse, frame accepted
//   frame_err    : 1-cycle pulse, frame short/long/bad command
module spi_display_slave
    import disp_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 256
) (
    input  logic               clk,
    input  logic               rst,
    spi_display_slave_if.slave spi,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [3:0]         an,
    output logic [1:0]         mode_o,
    output logic               frame_valid,
    output logic               frame_err
);

    localparam int CNT_W   = $clog2(FRAME_BITS + 2);
    localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    localparam logic [CNT_W-1:0]   BIT_FULL   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]   BIT_SAT    = CNT_W'(FRAME_BITS + 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // ---------------- pin synchronisers and edge detect ----------------
    logic [1:0] r_ss_sync;
    logic [1:0] r_sclk_sync;
    logic [1:0] r_mosi_sync;
    logic       r_ss_prev;
    logic       r_sclk_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ss_sync   <= 2'b11;   // idle-high so reset release is not a false select
            r_sclk_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_ss_prev   <= 1'b1;
            r_sclk_prev <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[0], spi.ss};
            r_sclk_sync <= {r_sclk_sync[0], spi.sclk};
            r_mosi_sync <= {r_mosi_sync[0], spi.mosi};
            r_ss_prev   <= r_ss_sync[1];
            r_sclk_prev <= r_sclk_sync[1];
        end
    end

    logic w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall, w_mosi;

    assign w_ss_fall   =  r_ss_prev   & ~r_ss_sync[1];
    assign w_ss_rise   = ~r_ss_prev   &  r_ss_sync[1];
    assign w_sclk_rise = ~r_sclk_prev &  r_sclk_sync[1];
    assign w_sclk_fall =  r_sclk_prev & ~r_sclk_sync[1];
    assign w_mosi      =  r_mosi_sync[1];

    // ---------------- SPI FSM and register file ----------------
    spi_state_t            r_state;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [FRAME_BITS-1:0] r_rx;
    logic [FRAME_BITS-1:0] r_tx;
    logic [FRAME_BITS-1:0] r_echo;
    logic                  r_miso;
    logic [3:0]            r_digit [4];
    logic [1:0]            r_mode;
    logic                  r_valid;
    logic                  r_err;

    logic [3:0] w_cmd;
    logic [3:0] w_data;
    logic       w_frame_ok;

    assign w_cmd      = r_rx[FRAME_BITS-1 -: 4];
    assign w_data     = r_rx[3:0];
    assign w_frame_ok = (r_bit_cnt == BIT_FULL) && cmd_legal(w_cmd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_echo    <= '0;
            r_miso    <= 1'b0;
            // NOTE: the digit store is four small flops, not a RAM, so it is
            // cleared by reset along with everything else.
            r_digit   <= '{default: '0};
            r_mode    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_state   <= ST_SHIFT;
                        r_bit_cnt <= '0;
                        // echo MSB goes out immediately so the first rising sclk sees it
                        r_miso    <= r_echo[FRAME_BITS-1];
                        r_tx      <= {r_echo[FRAME_BITS-2:0], 1'b0};
                    end
                end
                ST_SHIFT: begin
                    // deselect has priority: an sclk edge in the same cycle is dropped
                    if (w_ss_rise) begin
                        r_state <= ST_DONE;
                        r_miso  <= 1'b0;
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx <= {r_rx[FRAME_BITS-2:0], w_mosi};
                            // saturate one past full so overlong frames stay detectable
                            if (r_bit_cnt != BIT_SAT) begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                        if (w_sclk_fall) begin
                            r_miso <= r_tx[FRAME_BITS-1];
                            r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (w_frame_ok) begin
                        r_echo  <= r_rx;
                        r_valid <= 1'b1;
                        case (w_cmd)
                            CMD_DIG0: r_digit[0] <= w_data;
                            CMD_DIG1: r_digit[1] <= w_data;
                            CMD_DIG2: r_digit[2] <= w_data;
                            CMD_DIG3: r_digit[3] <= w_data;
                            CMD_MODE: r_mode     <= w_data[1:0];
                            default:  ;     // CMD_NOP: accepted, nothing stored
                        endcase
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- scan and blink timing ----------------
    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]         r_idx;
    logic [BLINK_W-1:0] r_round_cnt;
    logic               r_blink_off;
    logic [1:0]         r_mode_act;     // mode as seen by the display, updated per scan step

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_cnt  <= '0;
            r_idx       <= '0;
            r_round_cnt <= '0;
            r_blink_off <= 1'b0;
            r_mode_act  <= '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
            r_mode_act <= r_mode;
            if (r_idx == 2'd3) begin
                if (r_round_cnt == BLINK_LAST) begin
                    r_round_cnt <= '0;
                    r_blink_off <= ~r_blink_off;
                end else begin
                    r_round_cnt <= r_round_cnt + BLINK_W'(1);
                end
            end
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // ---------------- display drive ----------------
    logic [3:0] w_code;
    logic [6:0] w_seg;
    logic       w_blank;
    logic [6:0] r_seg;
    logic [3:0] r_an;
    logic       r_dp;

    // Digit codes are read every clock, so a write lands cleanly on the next clock.
    assign w_code  = r_digit[r_idx];
    assign w_blank = r_mode_act[MODE_BLINK] & r_blink_off;

    seg7_decode u_decode (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'hF;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_blank ? 4'hF : ~(4'b0001 << r_idx);
            r_dp  <= ~(r_mode_act[MODE_DP] & ~w_blank & (r_idx == DP_DIGIT));
        end
    end

    assign seg         = r_seg;
    assign an          = r_an;
    assign dp          = r_dp;
    assign mode_o      = r_mode;
    assign frame_valid = r_valid;
    assign frame_err   = r_err;
    assign spi.miso    = r_miso;

endmodule
